b_mcp_rx_arbiter: RTL and testbench

- Receive-domain (bclk) scheduler that shares one downstream consumer between NCH multi-cycle-path receive channels.
- Each channel exposes a data-ready flag, a one-cycle load-pulse input, and registered data.
- The block picks a ready channel round-robin and issues a single-cycle load pulse to it.
- It captures the returned data word and presents it on a valid/ready output port tagged with the channel index.

---
 rtl/b_mcp_rx_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_b_mcp_rx_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b_mcp_rx_arbiter.sv
// b_mcp_rx_arbiter
// Receive-domain (bclk) scheduler that shares one downstream consumer between
// NCH multi-cycle-path receive channels. A ready channel is picked round-robin,
// sent a one-cycle load pulse, and its returned word is captured and offered on
// a valid/ready port tagged with the channel index. A missing data pulse is
// abandoned after TO_CYC cycles and reported on err_to.
//
// Output handshake: out_valid rises with a captured word and stays high with
// out_data/out_ch frozen until a cycle where out_valid & out_ready are both 1;
// that cycle is the transfer, and out_valid drops on the next edge. out_ready
// while out_valid is low is ignored.
//
// dbg_state exposes the FSM state (0 IDLE, 1 LOAD, 2 CAPT, 3 HOLD).
//
// Optional build macro: B_MCP_RX_ARB_STATS_EN adds stats_clr, ch_cnt, to_cnt.
`timescale 1ns/1ps
module b_mcp_rx_arbiter #(
    parameter int NCH    = 4,
    parameter int DW     = 8,
    parameter int TO_CYC = 7
) (
    input  logic                   bclk,
    input  logic                   brst_n,
    input  logic [NCH-1:0]         ch_bvalid,
    input  logic [NCH-1:0]         ch_bvalid_out,
    input  logic [NCH*DW-1:0]      ch_bdata,
    output logic [NCH-1:0]         ch_bload,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(NCH)-1:0] out_ch,
    output logic                   err_to,
    output logic                   busy,
    output logic [1:0]             dbg_state
`ifdef B_MCP_RX_ARB_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [NCH*16-1:0]      ch_cnt,
    output logic [15:0]            to_cnt
`endif
);
    localparam int PW = $clog2(NCH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  r_g;
    logic [7:0]     r_to_cnt;
    logic [NCH-1:0] r_bload;
    logic           r_out_valid;
    logic [DW-1:0]  r_out_data;
    logic [PW-1:0]  r_out_ch;
    logic           r_err_to;

    logic           w_any;
    logic [PW-1:0]  w_gidx;
    logic [PW-1:0]  w_cand;
    logic           w_pulse;
    logic           w_to_hit;
    logic           w_hs;
    logic [PW-1:0]  w_g_inc;
    logic [DW-1:0]  w_bdata [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
        assign w_bdata[gi] = ch_bdata[gi*DW +: DW];
    end

    // Round-robin search: first requesting channel at or above r_ptr, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_cand = '0;
        for (int k = 0; k < NCH; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % NCH);
            if (!w_any && ch_bvalid[w_cand]) begin
                w_any  = 1'b1;
                w_gidx = w_cand;
            end
        end
    end

    // The granted channel's data pulse; the last wait cycle without it aborts.
    assign w_pulse  = ch_bvalid_out[r_g];
    assign w_to_hit = !w_pulse && (r_to_cnt == 8'(TO_CYC - 1));
    assign w_hs     = r_out_valid && out_ready;
    assign w_g_inc  = (r_g == PW'(NCH - 1)) ? '0 : r_g + PW'(1);

    // State register.
    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = LOAD;
            LOAD:    w_next = CAPT;
            CAPT:    if (w_pulse) w_next = HOLD;
                     else if (w_to_hit) w_next = IDLE;
            HOLD:    if (w_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Grant, load pulse, capture, timeout and round-robin pointer registers.
    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) begin
            r_ptr       <= '0;
            r_g         <= '0;
            r_to_cnt    <= '0;
            r_bload     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_err_to    <= 1'b0;
        end else begin
            r_bload  <= '0;
            r_err_to <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_g     <= w_gidx;
                        r_bload <= {{(NCH-1){1'b0}}, 1'b1} << w_gidx;
                    end
                end
                LOAD: r_to_cnt <= '0;
                CAPT: begin
                    if (w_pulse) begin
                        r_out_data  <= w_bdata[r_g];
                        r_out_ch    <= r_g;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                        if (w_to_hit) begin
                            r_err_to <= 1'b1;
                            r_ptr    <= w_g_inc;
                        end
                    end
                end
                HOLD: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        r_ptr       <= w_g_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ch_bload  = r_bload;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign err_to    = r_err_to;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

`ifdef B_MCP_RX_ARB_STATS_EN
    logic [15:0] r_ch_cnt [NCH];
    logic [15:0] r_tocnt;

    // Saturating delivery/timeout counters; clear wins over a same-cycle bump.
    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) begin
            for (int i = 0; i < NCH; i++) r_ch_cnt[i] <= '0;
            r_tocnt <= '0;
        end else if (stats_clr) begin
            for (int i = 0; i < NCH; i++) r_ch_cnt[i] <= '0;
            r_tocnt <= '0;
        end else begin
            if (r_state == HOLD && w_hs && r_ch_cnt[r_g] != 16'hFFFF)
                r_ch_cnt[r_g] <= r_ch_cnt[r_g] + 16'd1;
            if (r_state == CAPT && w_to_hit && r_tocnt != 16'hFFFF)
                r_tocnt <= r_tocnt + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
        assign ch_cnt[gi*16 +: 16] = r_ch_cnt[gi];
    end
    assign to_cnt = r_tocnt;
`endif

endmodule

// File: tb/tb_b_mcp_rx_arbiter.sv
// tb_b_mcp_rx_arbiter
// Directed bench for b_mcp_rx_arbiter (NCH=4, DW=8, TO_CYC=7). A channel
// responder answers each load pulse with a data pulse after resp_dly cycles
// (or never, when resp_en is cleared). A transaction-level model predicts
// grants, captured words, timeouts and busy from the latency rules and is
// checked on every falling edge; directed tests add literal expectations.
`timescale 1ns/1ps
module tb_b_mcp_rx_arbiter;
    localparam int NCH    = 4;
    localparam int DW     = 8;
    localparam int TO_CYC = 7;
    localparam int PW     = $clog2(NCH);

    // ---------------- clock / reset / DUT ----------------
    logic              bclk = 1'b0;
    logic              brst_n;
    logic [NCH-1:0]    ch_bvalid;
    logic [NCH-1:0]    ch_bvalid_out;
    logic [NCH*DW-1:0] ch_bdata;
    logic [NCH-1:0]    ch_bload;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [PW-1:0]     out_ch;
    logic              err_to;
    logic              busy;
    logic [1:0]        dbg_state;
`ifdef B_MCP_RX_ARB_STATS_EN
    logic              stats_clr;
    logic [NCH*16-1:0] ch_cnt;
    logic [15:0]       to_cnt;
`endif

    always #5 bclk = ~bclk;

    b_mcp_rx_arbiter #(.NCH(NCH), .DW(DW), .TO_CYC(TO_CYC)) dut (
        .bclk          (bclk),
        .brst_n        (brst_n),
        .ch_bvalid     (ch_bvalid),
        .ch_bvalid_out (ch_bvalid_out),
        .ch_bdata      (ch_bdata),
        .ch_bload      (ch_bload),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ch        (out_ch),
        .err_to        (err_to),
        .busy          (busy),
        .dbg_state     (dbg_state)
`ifdef B_MCP_RX_ARB_STATS_EN
        ,
        .stats_clr     (stats_clr),
        .ch_cnt        (ch_cnt),
        .to_cnt        (to_cnt)
`endif
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    bit resp_en  [NCH] = '{default: 1'b1};
    int resp_dly [NCH] = '{default: 1};
    int resp_cnt [NCH] = '{default: 0};

    // model state
    bit            m_open = 1'b0;
    bit            m_hold = 1'b0;
    bit            m_err  = 1'b0;
    int            m_age  = 0;
    int            m_g    = 0;
    int            m_ptr  = 0;
    logic [DW-1:0] m_data = '0;
    logic [PW-1:0] m_ch   = '0;

    logic [15:0] del_q[$];   // delivered {channel, data}
    logic [15:0] exp_q[$];   // expected delivery order

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    function automatic int rr_pick(input logic [NCH-1:0] req, input int ptr);
        logic [PW-1:0] c;
        for (int k = 0; k < NCH; k++) begin
            c = PW'((ptr + k) % NCH);
            if (req[c]) return (ptr + k) % NCH;
        end
        return -1;
    endfunction

    // ---------------- scoreboard / model compare ----------------
    initial begin : compare
        logic [NCH-1:0] exp_load;
        int g;
        forever begin
            @(negedge bclk);
            if (!brst_n) begin
                chk("rst_bload", 64'(ch_bload), 64'd0);
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_err_to", 64'(err_to), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_out_data", 64'(out_data), 64'd0);
                chk("rst_out_ch", 64'(out_ch), 64'd0);
                m_open = 1'b0; m_hold = 1'b0; m_err = 1'b0;
                m_age = 0; m_g = 0; m_ptr = 0; m_data = '0; m_ch = '0;
            end else begin
                exp_load = (m_open && !m_hold && m_age == 1) ? NCH'(1 << m_g) : '0;
                chk("bload", 64'(ch_bload), 64'(exp_load));
                chk("out_valid", 64'(out_valid), 64'(m_hold));
                chk("err_to", 64'(err_to), 64'(m_err));
                chk("busy", 64'(busy), 64'(m_open));
                chk("out_data", 64'(out_data), 64'(m_data));
                chk("out_ch", 64'(out_ch), 64'(m_ch));
                // advance model across the coming rising edge
                m_err = 1'b0;
                if (!m_open) begin
                    g = rr_pick(ch_bvalid, m_ptr);
                    if (g >= 0) begin
                        m_open = 1'b1;
                        m_g    = g;
                        m_age  = 1;
                    end
                end else if (m_hold) begin
                    if (out_ready) begin
                        del_q.push_back({8'(m_g), m_data});
                        m_hold = 1'b0;
                        m_open = 1'b0;
                        m_ptr  = (m_g + 1) % NCH;
                    end
                end else begin
                    if (m_age >= 2 && ch_bvalid_out[m_g]) begin
                        m_hold = 1'b1;
                        m_data = ch_bdata[m_g*DW +: DW];
                        m_ch   = PW'(m_g);
                    end else if (m_age == TO_CYC + 1) begin
                        m_err  = 1'b1;
                        m_open = 1'b0;
                        m_ptr  = (m_g + 1) % NCH;
                    end
                    m_age++;
                end
            end
        end
    end

    // ---------------- channel responder ----------------
    initial begin : responder
        ch_bvalid_out = '0;
        forever begin
            @(posedge bclk);
            #2;
            for (int i = 0; i < NCH; i++) begin
                ch_bvalid_out[i] = 1'b0;
                if (!brst_n) begin
                    resp_cnt[i] = 0;
                end else begin
                    if (resp_cnt[i] > 0) begin
                        resp_cnt[i]--;
                        if (resp_cnt[i] == 0) ch_bvalid_out[i] = 1'b1;
                    end
                    if (ch_bload[i] && resp_en[i]) resp_cnt[i] = resp_dly[i];
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge bclk);
        #2;
    endtask

    task automatic wait_load(input string name);
        int n = 0;
        do begin @(negedge bclk); #1; n++; end while (ch_bload == '0 && n < 40);
        if (ch_bload == '0) fail(name);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin @(negedge bclk); #1; n++; end while (!out_valid && n < 40);
        if (!out_valid) fail(name);
    endtask

    task automatic wait_err(input string name);
        int n = 0;
        do begin @(negedge bclk); #1; n++; end while (!err_to && n < 40);
        if (!err_to) fail(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin @(negedge bclk); #1; n++; end while ((busy || out_valid || n < 3) && n < 60);
        if (busy || out_valid) fail(name);
    endtask

    task automatic check_dels(input string name);
        if (del_q.size() < exp_q.size()) begin
            fail(name);
            return;
        end
        for (int i = 0; i < exp_q.size(); i++) chk(name, 64'(del_q[i]), 64'(exp_q[i]));
    endtask

    // ---------------- directed tests ----------------
    initial begin : main
        int n;
        brst_n    = 1'b0;
        ch_bvalid = '0;
        ch_bdata  = '0;
        out_ready = 1'b1;
`ifdef B_MCP_RX_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(negedge bclk);
        #1;
        chk("init_bload", 64'(ch_bload), 64'd0);
        chk("init_valid", 64'(out_valid), 64'd0);
        chk("init_busy", 64'(busy), 64'd0);
        step();
        brst_n = 1'b1;
        step();

        // single request on channel 2
        ch_bdata  = {8'h13, 8'h5A, 8'h11, 8'h10};
        ch_bvalid = 4'b0100;
        wait_load("t1_load");
        chk("t1_load", 64'(ch_bload), 64'h4);
        step();
        ch_bvalid = '0;
        @(negedge bclk); #1;
        chk("t1_load_once", 64'(ch_bload), 64'h0);
        wait_valid("t1_valid");
        chk("t1_data", 64'(out_data), 64'h5A);
        chk("t1_ch", 64'(out_ch), 64'd2);
        @(negedge bclk); #1;
        chk("t1_valid_once", 64'(out_valid), 64'd0);
        wait_idle("t1_idle");

        // backpressure: channels 0 and 1 ready, pointer sits at 3
        step();
        del_q.delete();
        exp_q = '{16'h0010, 16'h0111};
        ch_bdata  = {8'h13, 8'h12, 8'h11, 8'h10};
        ch_bvalid = 4'b0011;
        out_ready = 1'b0;
        wait_valid("t3_valid");
        chk("t3_ch", 64'(out_ch), 64'd0);
        chk("t3_data", 64'(out_data), 64'h10);
        repeat (10) begin
            @(negedge bclk); #1;
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_data", 64'(out_data), 64'h10);
            chk("t3_hold_ch", 64'(out_ch), 64'd0);
            chk("t3_no_load", 64'(ch_bload), 64'h0);
        end
        step();
        out_ready = 1'b1;
        wait_load("t3_next_load");
        chk("t3_next_load", 64'(ch_bload), 64'h2);
        step();
        ch_bvalid = '0;
        wait_idle("t3_idle");
        check_dels("t3_order");

        // timeout on channel 1, channel 2 ready afterwards
        step();
        resp_en[1] = 1'b0;
        ch_bvalid  = 4'b0010;
        wait_load("t4_load");
        chk("t4_load", 64'(ch_bload), 64'h2);
        step();
        ch_bvalid = 4'b0110;
        n = 0;
        do begin
            @(negedge bclk); #1; n++;
            chk("t4_no_valid", 64'(out_valid), 64'd0);
        end while (!err_to && n < 30);
        chk("t4_err_delay", 64'(n), 64'(TO_CYC + 1));
        @(negedge bclk); #1;
        chk("t4_err_once", 64'(err_to), 64'd0);
        chk("t4_next_grant", 64'(ch_bload), 64'h4);
        step();
        ch_bvalid  = '0;
        resp_en[1] = 1'b1;
        wait_idle("t4_idle");

        // reset while holding a word, then round-robin over all channels
        step();
        ch_bvalid = 4'b1000;
        out_ready = 1'b0;
        wait_valid("t5_valid");
        #1;
        brst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_load", 64'(ch_bload), 64'h0);
        chk("t5_rst_err", 64'(err_to), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        ch_bvalid = 4'b1111;
        out_ready = 1'b1;
        del_q.delete();
        exp_q = '{16'h0010, 16'h0111, 16'h0212, 16'h0313, 16'h0010};
        step();
        step();
        brst_n = 1'b1;
        wait_load("t5_first_load");
        chk("t5_first_load", 64'(ch_bload), 64'h1);
        n = 0;
        while (del_q.size() < 5 && n < 80) begin @(negedge bclk); #1; n++; end
        step();
        ch_bvalid = '0;
        wait_idle("t5_idle");
        check_dels("t5_rr_order");

`ifdef B_MCP_RX_ARB_STATS_EN
        // counters: 3 deliveries and 1 timeout on channel 3, then clear
        step();
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        del_q.delete();
        ch_bvalid = 4'b1000;
        n = 0;
        while (del_q.size() < 3 && n < 80) begin @(negedge bclk); #1; n++; end
        step();
        ch_bvalid = '0;
        wait_idle("t6_idle");
        step();
        resp_en[3] = 1'b0;
        ch_bvalid  = 4'b1000;
        wait_load("t6_load");
        step();
        ch_bvalid = '0;
        wait_err("t6_err");
        chk("t6_ch_cnt", ch_cnt, 64'h0003_0000_0000_0000);
        chk("t6_to_cnt", 64'(to_cnt), 64'd1);
        step();
        resp_en[3] = 1'b1;
        stats_clr  = 1'b1;
        @(negedge bclk); #1;
        chk("t6_clr_ch_cnt", ch_cnt, 64'd0);
        chk("t6_clr_to_cnt", 64'(to_cnt), 64'd0);
        step();
        stats_clr = 1'b0;
`endif

        repeat (3) @(negedge bclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
